// File: rtl/bitwise_op_arbiter_if.sv
// rtl/bitwise_op_arbiter_if.sv - request/response handshake bundle for bitwise_op_arbiter
interface bitwise_op_arbiter_if #(
  parameter int NBITS = 4
);
  logic             req0_val;
  logic             req0_rdy;
  logic [1:0]       req0_op;
  logic [NBITS-1:0] req0_in0;
  logic [NBITS-1:0] req0_in1;

  logic             req1_val;
  logic             req1_rdy;
  logic [1:0]       req1_op;
  logic [NBITS-1:0] req1_in0;
  logic [NBITS-1:0] req1_in1;

  logic             resp_val;
  logic             resp_rdy;
  logic             resp_id;
  logic [NBITS-1:0] resp_out;

  // Client side: issues requests, consumes responses
  modport master (
    output req0_val, req0_op, req0_in0, req0_in1,
    input  req0_rdy,
    output req1_val, req1_op, req1_in0, req1_in1,
    input  req1_rdy,
    input  resp_val, resp_id, resp_out,
    output resp_rdy
  );

  // Arbiter side
  modport slave (
    input  req0_val, req0_op, req0_in0, req0_in1,
    output req0_rdy,
    input  req1_val, req1_op, req1_in0, req1_in1,
    output req1_rdy,
    output resp_val, resp_id, resp_out,
    input  resp_rdy
  );
endinterface

// File: rtl/bitwise_op_arbiter.sv
// rtl/bitwise_op_arbiter.sv - two-port round-robin arbiter sharing one bitwise unit (optional BITWISE_OP_ARBITER_STATS_EN)
module bitwise_op_arbiter #(
  parameter int NBITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  bitwise_op_arbiter_if.slave bus
`ifdef BITWISE_OP_ARBITER_STATS_EN
  ,
  output logic [7:0]          grant_cnt0,
  output logic [7:0]          grant_cnt1
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic             r_resp_val;
  logic             r_resp_id;
  logic [NBITS-1:0] r_resp_out;

  logic             w_can_accept;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_xfer;
  logic             w_sel_id;
  logic [1:0]       w_op;
  logic [NBITS-1:0] w_a;
  logic [NBITS-1:0] w_b;
  logic [NBITS-1:0] w_result;

  function automatic logic [NBITS-1:0] f_apply(
    input logic [1:0]       op,
    input logic [NBITS-1:0] a,
    input logic [NBITS-1:0] b
  );
    logic [NBITS-1:0] y;
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = ~(a & b);
      2'b10:   y = a | b;
      default: y = ~(a | b);
    endcase
    return y;
  endfunction

  // The buffer can take a new result when empty, or when it is being drained this cycle
  assign w_can_accept = (r_state == ST_EMPTY) | (r_resp_val & bus.resp_rdy);

  // A lone requester always wins; on a tie the pointer decides
  assign w_grant0 = bus.req0_val & (~bus.req1_val | ~r_prio);
  assign w_grant1 = bus.req1_val & (~bus.req0_val |  r_prio);

  assign bus.req0_rdy = w_can_accept & w_grant0;
  assign bus.req1_rdy = w_can_accept & w_grant1;

  assign w_xfer0  = bus.req0_val & bus.req0_rdy;
  assign w_xfer1  = bus.req1_val & bus.req1_rdy;
  assign w_xfer   = w_xfer0 | w_xfer1;
  assign w_sel_id = w_xfer1;

  assign w_op     = w_sel_id ? bus.req1_op  : bus.req0_op;
  assign w_a      = w_sel_id ? bus.req1_in0 : bus.req0_in0;
  assign w_b      = w_sel_id ? bus.req1_in1 : bus.req0_in1;
  assign w_result = f_apply(w_op, w_a, w_b);

  assign bus.resp_val = r_resp_val;
  assign bus.resp_id  = r_resp_id;
  assign bus.resp_out = r_resp_out;

  // Buffer FSM: load on transfer, drain on consumer accept, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_resp_val <= 1'b0;
      r_resp_id  <= 1'b0;
      r_resp_out <= '0;
      r_prio     <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_state    <= ST_FULL;
        r_resp_val <= 1'b1;
        r_resp_id  <= w_sel_id;
        r_resp_out <= w_result;
        r_prio     <= ~w_sel_id;
      end else begin
        case (r_state)
          ST_FULL: begin
            if (bus.resp_rdy) begin
              r_state    <= ST_EMPTY;
              r_resp_val <= 1'b0;
            end
          end
          default: begin
            r_state    <= ST_EMPTY;
            r_resp_val <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BITWISE_OP_ARBITER_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  // Per-port transfer counters, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt0 <= 8'h00;
      r_cnt1 <= 8'h00;
    end else begin
      if (w_xfer0 && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_xfer1 && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// tb/tb_bitwise_op_arbiter.sv - directed self-checking bench for bitwise_op_arbiter
module tb_bitwise_op_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bitwise_op_arbiter_if #(.NBITS(4)) bus ();

`ifdef BITWISE_OP_ARBITER_STATS_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
`endif

  bitwise_op_arbiter #(.NBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BITWISE_OP_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_sweep [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_val = 1'b0; bus.req0_op = 2'b00; bus.req0_in0 = 4'h0; bus.req0_in1 = 4'h0;
    bus.req1_val = 1'b0; bus.req1_op = 2'b00; bus.req1_in0 = 4'h0; bus.req1_in1 = 4'h0;
    bus.resp_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.resp_val !== 1'b0 || bus.resp_out !== 4'b0000 || bus.resp_id !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d val=%b out=%b id=%b expected 0/0000/0", i, bus.resp_val, bus.resp_out, bus.resp_id);
      end
      n_checks++;
      if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rdy cyc=%0d rdy0=%b rdy1=%b expected 0/0", i, bus.req0_rdy, bus.req1_rdy);
      end
      step();
    end
  endtask

  task automatic test_op_sweep();
    bus.resp_rdy = 1'b1;
    bus.req0_val = 1'b1;
    bus.req0_in0 = 4'b1100;
    bus.req0_in1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bus.req0_op = 2'(i);
      #1;
      n_checks++;
      if (bus.req0_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_rdy op=%0d rdy0=%b expected 1", i, bus.req0_rdy);
      end
      step();
      n_checks++;
      if (bus.resp_val !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_out !== exp_sweep[i]) begin
        n_fail++;
        $display("FAIL sweep_result op=%0d val=%b id=%b out=%b expected 1/0/%b", i, bus.resp_val, bus.resp_id, bus.resp_out, exp_sweep[i]);
      end
    end
    bus.req0_val = 1'b0;
    step();
    n_checks++;
    if (bus.resp_val !== 1'b0 || bus.resp_out !== 4'b0001 || bus.resp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_drain val=%b out=%b id=%b expected 0/0001/0", bus.resp_val, bus.resp_out, bus.resp_id);
    end
  endtask

  task automatic test_contention();
    logic g;
    logic [3:0] e;
    do_reset();
    bus.resp_rdy = 1'b1;
    bus.req0_val = 1'b1; bus.req0_op = 2'b00; bus.req0_in0 = 4'b1111; bus.req0_in1 = 4'b0011;
    bus.req1_val = 1'b1; bus.req1_op = 2'b10; bus.req1_in0 = 4'b0000; bus.req1_in1 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2) == 1;
      e = g ? 4'b0101 : 4'b0011;
      #1;
      n_checks++;
      if (bus.req0_rdy !== ~g || bus.req1_rdy !== g) begin
        n_fail++;
        $display("FAIL contention_grant i=%0d rdy0=%b rdy1=%b expected %b/%b", i, bus.req0_rdy, bus.req1_rdy, ~g, g);
      end
      step();
      n_checks++;
      if (bus.resp_val !== 1'b1 || bus.resp_id !== g || bus.resp_out !== e) begin
        n_fail++;
        $display("FAIL contention_result i=%0d val=%b id=%b out=%b expected 1/%b/%b", i, bus.resp_val, bus.resp_id, bus.resp_out, g, e);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back_backpressure();
    do_reset();
    bus.resp_rdy = 1'b0;
    bus.req0_val = 1'b1; bus.req0_op = 2'b00; bus.req0_in0 = 4'b1100; bus.req0_in1 = 4'b1010;
    step();
    bus.req0_val = 1'b0;
    bus.req1_val = 1'b1; bus.req1_op = 2'b01; bus.req1_in0 = 4'b1111; bus.req1_in1 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.req1_rdy !== 1'b0 || bus.req0_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_rdy cyc=%0d rdy0=%b rdy1=%b expected 0/0", i, bus.req0_rdy, bus.req1_rdy);
      end
      n_checks++;
      if (bus.resp_val !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_out !== 4'b1000) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d val=%b id=%b out=%b expected 1/0/1000", i, bus.resp_val, bus.resp_id, bus.resp_out);
      end
      step();
    end
    bus.resp_rdy = 1'b1;
    #1;
    n_checks++;
    if (bus.req1_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_refill_rdy rdy1=%b expected 1", bus.req1_rdy);
    end
    step();
    n_checks++;
    if (bus.resp_val !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_out !== 4'b1001) begin
      n_fail++;
      $display("FAIL bp_refill val=%b id=%b out=%b expected 1/1/1001", bus.resp_val, bus.resp_id, bus.resp_out);
    end
    bus.req1_val = 1'b0;
    step();
    n_checks++;
    if (bus.resp_val !== 1'b0 || bus.resp_id !== 1'b1 || bus.resp_out !== 4'b1001) begin
      n_fail++;
      $display("FAIL bp_drain val=%b id=%b out=%b expected 0/1/1001", bus.resp_val, bus.resp_id, bus.resp_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.resp_rdy = 1'b0;
    bus.req0_val = 1'b1; bus.req0_op = 2'b10; bus.req0_in0 = 4'b0110; bus.req0_in1 = 4'b0001;
    step();
    bus.req0_val = 1'b0;
    n_checks++;
    if (bus.resp_val !== 1'b1 || bus.resp_out !== 4'b0111) begin
      n_fail++;
      $display("FAIL areset_load val=%b out=%b expected 1/0111", bus.resp_val, bus.resp_out);
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.resp_val !== 1'b0 || bus.resp_out !== 4'b0000 || bus.resp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clear val=%b out=%b id=%b expected 0/0000/0", bus.resp_val, bus.resp_out, bus.resp_id);
    end
    step();
    reset = 1'b1;
    bus.resp_rdy = 1'b1;
    bus.req0_val = 1'b1; bus.req0_op = 2'b00; bus.req0_in0 = 4'b1111; bus.req0_in1 = 4'b1010;
    bus.req1_val = 1'b1; bus.req1_op = 2'b11; bus.req1_in0 = 4'b0000; bus.req1_in1 = 4'b0000;
    #1;
    n_checks++;
    if (bus.req0_rdy !== 1'b1 || bus.req1_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_prio rdy0=%b rdy1=%b expected 1/0", bus.req0_rdy, bus.req1_rdy);
    end
    step();
    n_checks++;
    if (bus.resp_val !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_out !== 4'b1010) begin
      n_fail++;
      $display("FAIL areset_first val=%b id=%b out=%b expected 1/0/1010", bus.resp_val, bus.resp_id, bus.resp_out);
    end
    idle_inputs();
    step();
  endtask

`ifdef BITWISE_OP_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++;
    if (grant_cnt0 !== 8'h00 || grant_cnt1 !== 8'h00) begin
      n_fail++;
      $display("FAIL stats_reset cnt0=%h cnt1=%h expected 00/00", grant_cnt0, grant_cnt1);
    end
    bus.resp_rdy = 1'b1;
    bus.req0_val = 1'b1;
    repeat (300) step();
    bus.req0_val = 1'b0;
    bus.req1_val = 1'b1;
    repeat (2) step();
    bus.req1_val = 1'b0;
    step();
    n_checks++;
    if (grant_cnt0 !== 8'hFF || grant_cnt1 !== 8'h02) begin
      n_fail++;
      $display("FAIL stats_count cnt0=%h cnt1=%h expected ff/02", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sweep[0] = 4'b1000;
    exp_sweep[1] = 4'b0111;
    exp_sweep[2] = 4'b1110;
    exp_sweep[3] = 4'b0001;
    reset = 1'b0;
    idle_inputs();

    test_reset();
    test_op_sweep();
    test_contention();
    test_back_to_back_backpressure();
    test_async_reset();
`ifdef BITWISE_OP_ARBITER_STATS_EN
    test_stats();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitwise_op_arbiter.md
Name: bitwise_op_arbiter

Overview:
- Shares one NBITS-wide bitwise logic unit (AND/NAND/OR/NOR) between two requesters.
- Round-robin arbitration over two val/rdy request ports.
- Registers each result into a one-entry output buffer.
- Returns the result on a single val/rdy response port, tagged with the requester id.
- Sits between issuing clients and the combinational bitwise gate datapath, and sequences all access to that datapath.

Parameters:
- NBITS, 4, operand and result width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_val  input  1  requester 0 has a valid operation.
- req0_rdy  output  1  requester 0 is accepted this cycle.
- req0_op  input  2  operation code for requester 0.
- req0_in0  input  NBITS  operand A for requester 0.
- req0_in1  input  NBITS  operand B for requester 0.
- req1_val  input  1  requester 1 has a valid operation.
- req1_rdy  output  1  requester 1 is accepted this cycle.
- req1_op  input  2  operation code for requester 1.
- req1_in0  input  NBITS  operand A for requester 1.
- req1_in1  input  NBITS  operand B for requester 1.
- resp_val  output  1  result buffer holds a valid result.
- resp_rdy  input  1  consumer accepts the result.
- resp_id  output  1  requester that produced the result.
- resp_out  output  NBITS  result.

Behaviour:
- Op encoding: 2'b00 AND, 2'b01 NAND, 2'b10 OR, 2'b11 NOR. Bitwise across all NBITS bits.
- State: EMPTY or FULL (one-entry buffer), plus a 1-bit priority pointer prio. prio=0 means req0 wins a tie.
- While reset is low, asynchronously: state=EMPTY, resp_val=0, resp_id=0, resp_out=0, prio=0.
- can_accept = (state==EMPTY) | (resp_val & resp_rdy). Same-cycle drain and refill is allowed, giving full throughput.
- Grant, combinational:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester equal to prio is granted.
- reqN_rdy = can_accept & grant_N.
  - At most one rdy is high per cycle.
  - reqN_rdy may depend on the other port's val, but never on its own val combinationally beyond the grant.
- A transfer occurs when reqN_val & reqN_rdy.
- On a transfer in cycle C, at edge C→C+1:
  - resp_out = op(inN0, inN1), resp_id = N, state = FULL.
  - prio = ~N; the loser gains priority.
- prio changes only on a transfer.
- Latency: exactly 1 cycle from request transfer to resp_val=1.
- FULL with resp_rdy=0: resp_val, resp_id and resp_out hold stable. Both req rdy are 0.
- FULL with resp_rdy=1 and no transfer: next state EMPTY, resp_val=0. resp_out and resp_id keep their last values.
- FULL with resp_rdy=1 and a transfer: stays FULL with the new result. No bubble.
- Requests with val=0 are ignored; operands are don't-care.
- Reset asserted mid-operation: the buffered result is discarded and prio returns to 0. Requesters must reissue.

Optional Feature:
- Macro: BITWISE_OP_ARBITER_STATS_EN.
- When defined, adds outputs grant_cnt0 and grant_cnt1 (output, 8 bits each).
  - Each counts transfers on its request port.
  - Saturating at 8'hFF.
  - Cleared to 0 on reset.
  - Updated at the same edge as the transfer.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: both val=0 for 5 cycles → resp_val=0, resp_out=0, resp_id=0, both rdy equal to can_accept & grant (0).
- Single op sweep, resp_rdy=1: req0 with in0=4'b1100, in1=4'b1010, ops 00/01/10/11 in consecutive cycles → resp_out 4'b1000, 4'b0111, 4'b1110, 4'b0001 with resp_id=0, each 1 cycle after the transfer, back-to-back with no bubbles.
- Contention, resp_rdy=1: both valid every cycle; req0 AND 4'b1111&4'b0011, req1 OR 4'b0000|4'b0101.
  - Grants alternate 0,1,0,1.
  - Results alternate 4'b0011 (id 0) and 4'b0101 (id 1).
- Backpressure: buffer FULL with result 4'b1000 and resp_rdy=0 for 3 cycles while req1_val=1.
  - req1_rdy=0 and the output is stable.
  - When resp_rdy=1, same-cycle drain and accept; the next cycle shows the req1 result.
- Async reset mid-transaction: assert reset while FULL, between clock edges.
  - resp_val falls to 0 immediately.
  - After release, both valid → req0 is granted first (prio=0).
- With BITWISE_OP_ARBITER_STATS_EN: 300 req0 transfers and 2 req1 transfers → grant_cnt0=8'hFF (saturated), grant_cnt1=8'h02.
